// File: rtl/aes_pkg.sv
// aes_pkg: ShiftRows mode encodings, per-row shift offsets and block-width check.
package aes_pkg;

   localparam logic [1:0] SR_FWD = 2'b00;
   localparam logic [1:0] SR_INV = 2'b01;
   localparam logic [1:0] SR_BYP = 2'b10;
   localparam logic [1:0] SR_RSV = 2'b11;

   // Rijndael widens the row-2/row-3 shifts only for 256-bit blocks.
   function automatic int sr_offset(input int nb, input int row);
      if (row == 0) return 0;
      if (nb == 8 && row >= 2) return row + 1;
      return row;
   endfunction

   function automatic bit nb_legal(input int nb);
      return nb == 4 || nb == 6 || nb == 8;
   endfunction

endpackage

// File: rtl/rijndael_shiftrows_perm.sv
// rijndael_shiftrows_perm: combinational ShiftRows / InvShiftRows / bypass byte permutation.
module rijndael_shiftrows_perm
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [32*NB-1:0] data,
   input  logic [1:0]       mode,
   output logic [32*NB-1:0] perm
);

   localparam int W = 32*NB;

   // Byte k is s(k%4, k/4); the inverse source adds NB before the modulo so NB=6 wraps correctly.
   for (genvar k = 0; k < 4*NB; k++) begin : g_byte
      localparam int R = k % 4;
      localparam int C = k / 4;
      localparam int F = 4*((C + sr_offset(NB, R)) % NB) + R;
      localparam int I = 4*((C + NB - sr_offset(NB, R)) % NB) + R;
      assign perm[W-1-8*k -: 8] = mode == SR_FWD ? data[W-1-8*F -: 8] :
                                  mode == SR_INV ? data[W-1-8*I -: 8] :
                                                   data[W-1-8*k -: 8];
   end

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// aes_shiftrows_pipe: registered ShiftRows stage with valid/ready handshake.
// Define AES_SHIFTROWS_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module aes_shiftrows_pipe
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*NB-1:0]  in_data,
   input  logic [1:0]        in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   localparam int W = 32*NB;

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
   end

   logic [W-1:0] perm;
   logic         err;

   rijndael_shiftrows_perm #(.NB(NB)) u_perm (
      .data(in_data),
      .mode(in_mode),
      .perm(perm)
   );

   assign err = in_mode == SR_RSV;

`ifdef AES_SHIFTROWS_SKID_EN
   logic [W-1:0]     skid_data;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_err;
   logic             skid_full;
   logic             load;

   assign in_ready = !skid_full;
   assign load     = !out_valid || out_ready;

   // While the skid holds a beat in_ready is low, so a free output slot always takes the skid first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
         skid_full <= 1'b0;
         skid_data <= '0;
         skid_tag  <= '0;
         skid_err  <= 1'b0;
      end else if (load) begin
         out_valid <= skid_full || in_valid;
         skid_full <= 1'b0;
         if (skid_full || in_valid) begin
            out_data <= skid_full ? skid_data : perm;
            out_tag  <= skid_full ? skid_tag : in_tag;
            out_err  <= skid_full ? skid_err : err;
         end
      end else if (in_valid && !skid_full) begin
         skid_full <= 1'b1;
         skid_data <= perm;
         skid_tag  <= in_tag;
         skid_err  <= err;
      end
   end
`else
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= perm;
            out_tag  <= in_tag;
            out_err  <= err;
         end
      end
   end
`endif

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// tb_aes_shiftrows_pipe: directed checks of permutation, handshake, backpressure and reset.
module tb_aes_shiftrows_pipe;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, out_err;
   logic [127:0] in_data, out_data;
   logic [1:0]   in_mode;
   logic [3:0]   in_tag, out_tag;

   logic         v6, r6, ov6, oe6, v8, r8, ov8, oe8;
   logic [191:0] d6, od6;
   logic [255:0] d8, od8;
   logic [1:0]   m6, m8;
   logic [3:0]   ot6, ot8;
   logic         one = 1'b1;
   logic [3:0]   zero_tag = 4'h0;

   int total = 0;
   int bad   = 0;

   localparam logic [127:0] V4_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] V4_FWD = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] V4_PAT = 128'h0123456789abcdef0123456789abcdef;
   localparam logic [127:0] V4_PFW = 128'h01ab45ef8923cd6701ab45ef8923cd67;
   localparam logic [191:0] V6_IN  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [191:0] V6_FWD = 192'h00050a0f04090e13080d12170c11160310150207_1401060b;
   localparam logic [255:0] V8_IN  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] V8_FWD = 256'h00050e130409121708_0d161b0c111a1f10151e031419020718_1d060b1c010a0f;

   always #5 clk = ~clk;

   aes_shiftrows_pipe #(.NB(4), .TAG_W(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_err(out_err)
   );

   aes_shiftrows_pipe #(.NB(6), .TAG_W(4)) u6 (
      .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6),
      .in_data(d6), .in_mode(m6), .in_tag(zero_tag),
      .out_valid(ov6), .out_ready(one), .out_data(od6),
      .out_tag(ot6), .out_err(oe6)
   );

   aes_shiftrows_pipe #(.NB(8), .TAG_W(4)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
      .in_data(d8), .in_mode(m8), .in_tag(zero_tag),
      .out_valid(ov8), .out_ready(one), .out_data(od8),
      .out_tag(ot8), .out_err(oe8)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [127:0] d, input logic [1:0] m, input logic [3:0] t);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      in_tag   = t;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic offer(input int t);
      in_valid = t <= 3;
      in_tag   = 4'(t);
      in_data  = {16{4'h0, 4'(t)}};
      in_mode  = SR_BYP;
   endtask

   initial begin
      logic       rdy [4];
      logic       exp_rdy [4];
      logic [3:0] got_tag [3];
      logic [127:0] got_data [3];
      int         got_cyc [3];
      int         nt, n;
      logic       fire;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_mode = SR_FWD; in_tag = '0;
      v6 = 1'b0; d6 = '0; m6 = SR_FWD;
      v8 = 1'b0; d8 = '0; m8 = SR_FWD;
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_err", out_err, 0);
      #19 rst_n = 1'b1;
      @(posedge clk); #1;

      beat(V4_IN, SR_FWD, 4'h5);
      chk("fwd4_valid", out_valid, 1);
      chk("fwd4_data", out_data, V4_FWD);
      chk("fwd4_tag", out_tag, 4'h5);
      chk("fwd4_err", out_err, 0);

      beat(V4_FWD, SR_INV, 4'h6);
      chk("inv4_data", out_data, V4_IN);
      chk("inv4_tag", out_tag, 4'h6);

      beat(V4_PAT, SR_RSV, 4'h7);
      chk("rsv_data", out_data, V4_PAT);
      chk("rsv_err", out_err, 1);
      beat(V4_PAT, SR_FWD, 4'h8);
      chk("after_rsv_data", out_data, V4_PFW);
      chk("after_rsv_err", out_err, 0);
      beat(V4_FWD, SR_BYP, 4'h9);
      chk("byp_data", out_data, V4_FWD);
      @(posedge clk); #1;
      chk("drained_valid", out_valid, 0);

      v6 = 1'b1; d6 = V6_IN; m6 = SR_FWD;
      v8 = 1'b1; d8 = V8_IN; m8 = SR_FWD;
      @(posedge clk); #1;
      chk("fwd6_data", od6, V6_FWD);
      chk("fwd8_data", od8, V8_FWD);
      chk("fwd8_r3c0", od8[255-24 -: 8], 8'h13);
      d6 = od6; m6 = SR_INV;
      d8 = od8; m8 = SR_INV;
      @(posedge clk); #1;
      chk("inv6_data", od6, V6_IN);
      chk("inv8_data", od8, V8_IN);
      v6 = 1'b0; v8 = 1'b0;

      // Backpressure: three beats offered against a four-cycle stall.
`ifdef AES_SHIFTROWS_SKID_EN
      exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
      exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
      out_ready = 1'b0;
      nt = 1;
      for (int i = 0; i < 4; i++) begin
         offer(nt);
         #2;
         rdy[i] = in_ready;
         fire = in_valid && in_ready;
         @(posedge clk); #1;
         if (fire) nt++;
      end
      for (int i = 0; i < 4; i++) chk($sformatf("stall_rdy%0d", i), rdy[i], exp_rdy[i]);
`ifdef AES_SHIFTROWS_SKID_EN
      chk("stall_accepted", nt - 1, 2);
`else
      chk("stall_accepted", nt - 1, 1);
`endif
      chk("stall_valid", out_valid, 1);
      chk("stall_tag", out_tag, 4'h1);

      out_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 10 && n < 3; i++) begin
         offer(nt);
         #2;
         if (out_valid) begin
            got_tag[n]  = out_tag;
            got_data[n] = out_data;
            got_cyc[n]  = i;
            n++;
         end
         fire = in_valid && in_ready;
         @(posedge clk); #1;
         if (fire) nt++;
      end
      offer(4);
      chk("release_count", n, 3);
      for (int j = 0; j < n && j < 3; j++) begin
         chk($sformatf("release_tag%0d", j), got_tag[j], 4'(j + 1));
         chk($sformatf("release_data%0d", j), got_data[j], {16{4'h0, 4'(j + 1)}});
         chk($sformatf("release_cyc%0d", j), got_cyc[j], j);
      end

      // Reset with beats in flight.
      out_ready = 1'b0;
      offer(1);
      @(posedge clk); #1;
      offer(2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_tag", out_tag, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #2 rst_n = 1'b1;
      #1;
      chk("postrst_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("postrst_valid%0d", i), out_valid, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
